// File: rtl/bit_serializer_if.sv
// bit_serializer_if: load handshake, stall and serial-stream signals of the bit serializer.
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             hold;
  logic             x;
  logic             x_valid;
  logic             done;
  modport master (output load_valid, data_in, hold, input load_ready, x, x_valid, done);
  modport slave  (input load_valid, data_in, hold, output load_ready, x, x_valid, done);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial stream with done pulse.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to each word.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  bit_serializer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic p, p_nx;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             done_q, done_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      p      <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      sr     <= sr_nx;
      cnt    <= cnt_nx;
      done_q <= done_nx;
`ifdef BIT_SERIALIZER_PARITY_EN
      p      <= p_nx;
`endif
    end
  // load_ready is high exactly in IDLE, so load_valid alone completes the handshake there
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    p_nx     = p;
`endif
    if (state == IDLE && bus.load_valid) begin
      state_nx = SHIFT;
      sr_nx    = bus.data_in;
      cnt_nx   = CW'(WIDTH);
`ifdef BIT_SERIALIZER_PARITY_EN
      p_nx     = ^bus.data_in;
`endif
    end else if (state == SHIFT && !bus.hold) begin
      sr_nx  = sr << 1;
      cnt_nx = cnt - 1'b1;
      if (cnt == CW'(1)) begin
`ifdef BIT_SERIALIZER_PARITY_EN
        state_nx = PARITY;
`else
        state_nx = IDLE;
        done_nx  = 1'b1;
`endif
      end
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    else if (state == PARITY && !bus.hold) begin
      state_nx = IDLE;
      done_nx  = 1'b1;
    end
`endif
  end
  assign bus.load_ready = state == IDLE;
  assign bus.x_valid    = state != IDLE;
  assign bus.done       = done_q;
`ifdef BIT_SERIALIZER_PARITY_EN
  assign bus.x = state == SHIFT ? sr[WIDTH-1] : state == PARITY ? p : 1'b0;
`else
  assign bus.x = state == SHIFT ? sr[WIDTH-1] : 1'b0;
`endif
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of streaming, hold, back-to-back loads and async reset.
module tb_bit_serializer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  bit_serializer_if #(.WIDTH(W)) bus();
  bit_serializer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_check(input string tag, input logic exp_done);
    check({tag, "_ready"}, bus.load_ready, 1);
    check({tag, "_x"}, bus.x, 0);
    check({tag, "_xv"}, bus.x_valid, 0);
    check({tag, "_done"}, bus.done, exp_done);
  endtask
  // entered in cycle k+1; returns in the first IDLE cycle after the stream
  task automatic bits(input logic [W-1:0] w, input int hb, input int hn);
    for (int i = 0; i < W; i++) begin
      int reps = (i == hb) ? hn + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        bus.hold = r < reps - 1;
        check($sformatf("bit%0d_%0h", i, w), bus.x, w[W-1-i]);
        check("xv", bus.x_valid, 1);
        check("ready_busy", bus.load_ready, 0);
        check("done_busy", bus.done, 0);
        tick;
      end
    end
    bus.hold = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    check($sformatf("parity_%0h", w), bus.x, ^w);
    check("parity_xv", bus.x_valid, 1);
    tick;
`endif
  endtask
  task automatic run_word(input logic [W-1:0] w, input int hb, input int hn);
    bus.load_valid = 1'b1;
    bus.data_in = w;
    tick;
    bus.load_valid = 1'b0;
    bits(w, hb, hn);
    idle_check("end", 1);
    tick;
    idle_check("after", 0);
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.data_in = '0;
    bus.hold = 1'b0;
    #1;
    idle_check("reset", 0);
    tick;
    reset = 1'b1;
    idle_check("released", 0);
    run_word(8'b1001_1010, -1, 0);
    run_word(8'h07, -1, 0);
    run_word(8'h03, -1, 0);
    run_word(8'hB6, 2, 3);
    // back-to-back: valid stays high with the second word offered while busy
    bus.load_valid = 1'b1;
    bus.data_in = 8'hA5;
    tick;
    bus.data_in = 8'h3C;
    bits(8'hA5, -1, 0);
    check("b2b_done", bus.done, 1);
    check("b2b_ready", bus.load_ready, 1);
    tick;
    bus.load_valid = 1'b0;
    bits(8'h3C, -1, 0);
    idle_check("b2b_end", 1);
    tick;
    // hold in IDLE must not block the handshake
    bus.hold = 1'b1;
    bus.load_valid = 1'b1;
    bus.data_in = 8'hC1;
    tick;
    bus.hold = 1'b0;
    bus.load_valid = 1'b0;
    bits(8'hC1, -1, 0);
    idle_check("hidle_end", 1);
    tick;
    // asynchronous reset in the middle of a word
    bus.load_valid = 1'b1;
    bus.data_in = 8'hFF;
    tick;
    bus.load_valid = 1'b0;
    tick;
    check("pre_rst_x", bus.x, 1);
    #2 reset = 1'b0;
    #1;
    idle_check("async_rst", 0);
    tick;
    reset = 1'b1;
    idle_check("rst_rel", 0);
    run_word(8'h81, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
